// File: rtl/vc_pop_arbiter_if.sv
// Signal bundle between the VC pop arbiter, its two source VC FIFOs and the
// two destination FIFOs D0/D1.
interface vc_pop_arbiter_if #(
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 8
);
    logic                  empty_fifo_VC0;
    logic                  empty_fifo_VC1;
    logic [DATA_WIDTH-1:0] data_out_VC0;
    logic [DATA_WIDTH-1:0] data_out_VC1;
    logic                  almost_full_D0;
    logic                  almost_full_D1;
    logic                  pop_VC0_fifo;
    logic                  pop_VC1_fifo;
    logic [DATA_WIDTH-1:0] data_D0;
    logic                  push_D0;
    logic [DATA_WIDTH-1:0] data_D1;
    logic                  push_D1;
    logic [CNT_WIDTH-1:0]  count_D0;
    logic [CNT_WIDTH-1:0]  count_D1;
    logic                  active;

    // Arbiter side
    modport master (
        input  empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1,
        input  almost_full_D0, almost_full_D1,
        output pop_VC0_fifo, pop_VC1_fifo, data_D0, push_D0, data_D1, push_D1,
        output count_D0, count_D1, active
    );

    // FIFO / environment side
    modport slave (
        output empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1,
        output almost_full_D0, almost_full_D1,
        input  pop_VC0_fifo, pop_VC1_fifo, data_D0, push_D0, data_D1, push_D1,
        input  count_D0, count_D1, active
    );
endinterface

// File: rtl/vc_pop_arbiter.sv
// Read-side engine for VC0/VC1: arbitrates pops with a VC0 burst limit, captures
// the FIFO word one cycle after the pop and routes it to D0/D1 by its dest bit.
module vc_pop_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic             clk,
    input  logic             reset,
    vc_pop_arbiter_if.master bus
);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, PAUSE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  pause;
    logic                  any_ready;
    logic                  grant_vc0;
    logic                  grant_vc1;
    logic [BW-1:0]         burst_cnt;
    logic                  pend_valid;
    logic                  pend_vc;
    logic [DATA_WIDTH-1:0] rd_word;

    assign pause     = bus.almost_full_D0 | bus.almost_full_D1;
    assign any_ready = !bus.empty_fifo_VC0 || !bus.empty_fifo_VC1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Pops are decided from the same-cycle empty flags so a FIFO holding one
    // word is popped exactly once before its empty flag rises.
    always_comb begin
        state_nxt = state;
        grant_vc0 = 1'b0;
        grant_vc1 = 1'b0;
        case (state)
            IDLE: begin
                if (pause)          state_nxt = PAUSE;
                else if (any_ready) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (pause) begin
                    state_nxt = PAUSE;
                end else begin
                    if (!any_ready && !pend_valid) state_nxt = IDLE;
                    if (!bus.empty_fifo_VC1 &&
                        (bus.empty_fifo_VC0 || burst_cnt == BW'(MAX_BURST)))
                        grant_vc1 = 1'b1;
                    else if (!bus.empty_fifo_VC0)
                        grant_vc0 = 1'b1;
                end
            end
            PAUSE: begin
                if (!pause) state_nxt = any_ready ? ACTIVE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.pop_VC0_fifo = grant_vc0;
    assign bus.pop_VC1_fifo = grant_vc1;
    assign bus.active       = (state == ACTIVE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            burst_cnt <= '0;
        else if (bus.empty_fifo_VC1 || grant_vc1)
            burst_cnt <= '0;
        else if (grant_vc0 && burst_cnt != BW'(MAX_BURST))
            burst_cnt <= burst_cnt + BW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid <= 1'b0;
            pend_vc    <= 1'b0;
        end else begin
            pend_valid <= grant_vc0 | grant_vc1;
            pend_vc    <= grant_vc1;
        end
    end

    // The FIFO word is valid the cycle after the pop; it is routed straight
    // into the destination registers, giving a two-cycle pop-to-push latency.
    assign rd_word = pend_vc ? bus.data_out_VC1 : bus.data_out_VC0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.push_D0  <= 1'b0;
            bus.push_D1  <= 1'b0;
            bus.data_D0  <= '0;
            bus.data_D1  <= '0;
            bus.count_D0 <= '0;
            bus.count_D1 <= '0;
        end else begin
            bus.push_D0 <= pend_valid && !rd_word[DATA_WIDTH-2];
            bus.push_D1 <= pend_valid &&  rd_word[DATA_WIDTH-2];
            if (pend_valid && !rd_word[DATA_WIDTH-2]) begin
                bus.data_D0  <= rd_word;
                bus.count_D0 <= bus.count_D0 + CNT_WIDTH'(1);
            end
            if (pend_valid && rd_word[DATA_WIDTH-2]) begin
                bus.data_D1  <= rd_word;
                bus.count_D1 <= bus.count_D1 + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Bench for vc_pop_arbiter: queue-based VC FIFO models, a word scoreboard keyed
// by expected push cycle, directed scenarios followed by a randomized phase.
module tb_vc_pop_arbiter;
    localparam int DW = 6;
    localparam int MB = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset;

    vc_pop_arbiter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    vc_pop_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int streak = 0;
    int npush  = 0;
    int written = 0;
    int n;
    int g_before;
    int np_before;
    int c0_before;
    logic last_p0, last_p1;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            exp_cyc[$];
    logic [DW-1:0] exp_word[$];
    int            glog[$];
    int            gcyc[$];
    logic [CW-1:0] m_cnt0, m_cnt1;
    logic [DW-1:0] m_d0, m_d1;
    int            exp_fair[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifos();
        bus.empty_fifo_VC0 = (q0.size() == 0);
        bus.empty_fifo_VC1 = (q1.size() == 0);
    endtask

    task automatic load(input bit vc, input logic [DW-1:0] w);
        if (vc) q1.push_back(w);
        else    q0.push_back(w);
        written++;
        drive_fifos();
    endtask

    // One clock: check outputs at negedge, then model the FIFOs just after posedge.
    task automatic step();
        logic p0, p1, pz, e0, e1, vc_exp;
        logic [DW-1:0] w;
        @(negedge clk);
        p0 = bus.pop_VC0_fifo;
        p1 = bus.pop_VC1_fifo;
        last_p0 = p0;
        last_p1 = p1;
        pz = bus.almost_full_D0 | bus.almost_full_D1;
        if (reset !== 1'b1) begin
            exp_cyc.delete();
            exp_word.delete();
            m_cnt0 = '0; m_cnt1 = '0; m_d0 = '0; m_d1 = '0;
            streak = 0;
            npush  = 0;
            check("rst_pops",   {p0, p1}, 0);
            check("rst_push",   {bus.push_D0, bus.push_D1}, 0);
            check("rst_counts", {bus.count_D0, bus.count_D1}, 0);
            check("rst_data",   {bus.data_D0, bus.data_D1}, 0);
        end else begin
            e0 = 1'b0;
            e1 = 1'b0;
            if (exp_cyc.size() > 0 && exp_cyc[0] == cyc) begin
                void'(exp_cyc.pop_front());
                w = exp_word.pop_front();
                if (w[DW-2]) begin e1 = 1'b1; m_d1 = w; m_cnt1++; end
                else         begin e0 = 1'b1; m_d0 = w; m_cnt0++; end
                npush++;
            end
            check("push_D0",  bus.push_D0, e0);
            check("push_D1",  bus.push_D1, e1);
            check("data_D0",  bus.data_D0, m_d0);
            check("data_D1",  bus.data_D1, m_d1);
            check("count_D0", bus.count_D0, m_cnt0);
            check("count_D1", bus.count_D1, m_cnt1);
            if (p0 || p1) begin
                check("pop_overlap", p0 & p1, 0);
                check("pop_in_pause", pz, 0);
                vc_exp = (q0.size() == 0) || (streak >= MB && q1.size() > 0);
                check("grant_vc", p1, vc_exp);
                if (p1) check("pop_vc1_nonempty", q1.size() > 0, 1);
                else    check("pop_vc0_nonempty", q0.size() > 0, 1);
                glog.push_back(p1 ? 1 : 0);
                gcyc.push_back(cyc);
                if (p1 && q1.size() > 0) begin
                    exp_cyc.push_back(cyc + 2);
                    exp_word.push_back(q1[0]);
                end else if (!p1 && q0.size() > 0) begin
                    exp_cyc.push_back(cyc + 2);
                    exp_word.push_back(q0[0]);
                end
            end
            // Length of the current VC0 run while VC1 is waiting, capped at MB.
            if (q1.size() == 0 || p1) streak = 0;
            else if (p0 && streak < MB) streak++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (p0 && q0.size() > 0) bus.data_out_VC0 = q0.pop_front();
        if (p1 && q1.size() > 0) bus.data_out_VC1 = q1.pop_front();
        drive_fifos();
    endtask

    task automatic drain(input string tag, input int bound);
        int k;
        k = 0;
        while ((q0.size() > 0 || q1.size() > 0 || exp_cyc.size() > 0 || bus.active !== 1'b0)
               && k < bound) begin
            step();
            k++;
        end
        check({tag, "_drain_bound"}, k < bound, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        bus.almost_full_D0 = 1'b0;
        bus.almost_full_D1 = 1'b0;
        bus.data_out_VC0 = '0;
        bus.data_out_VC1 = '0;
        drive_fifos();

        // Reset held with both FIFOs non-empty
        load(0, 6'h01); load(0, 6'h12); load(1, 6'h21); load(1, 6'h32);
        repeat (3) begin
            step();
            check("rst_active", bus.active, 0);
        end
        q0.delete(); q1.delete(); drive_fifos();
        written = 0;

        // VC0 only, mixed destinations
        reset = 1'b1;
        glog.delete(); gcyc.delete();
        load(0, 6'b000001); load(0, 6'b010010); load(0, 6'b000011);
        drain("vc0only", 50);
        check("vc0_pop_count", glog.size(), 3);
        if (gcyc.size() == 3) check("vc0_back_to_back", gcyc[2] - gcyc[0], 2);
        check("vc0_count_D0", bus.count_D0, 2);
        check("vc0_count_D1", bus.count_D1, 1);
        check("vc0_idle", bus.active, 0);

        // Fairness: VC0 x8, VC1 x2
        glog.delete(); gcyc.delete();
        for (int i = 0; i < 8; i++) load(0, DW'($urandom_range(0, 31)));
        for (int i = 0; i < 2; i++) load(1, DW'($urandom_range(32, 63)));
        drain("fair", 100);
        check("fair_len", glog.size(), 10);
        for (int i = 0; i < 10 && i < glog.size(); i++) check("fair_order", glog[i], exp_fair[i]);
        if (gcyc.size() == 10) check("fair_back_to_back", gcyc[9] - gcyc[0], 9);

        // Pause mid-stream
        for (int i = 0; i < 12; i++) load(0, DW'($urandom()));
        repeat (3) step();
        bus.almost_full_D1 = 1'b1;
        np_before = npush;
        g_before  = glog.size();
        repeat (5) step();
        check("pause_inflight_pushes", npush - np_before, 2);
        check("pause_no_pops", glog.size(), g_before);
        check("pause_state", bus.active, 0);
        bus.almost_full_D1 = 1'b0;
        step();
        check("resume_wait", last_p0, 0);
        step();
        check("resume_pop", last_p0, 1);
        drain("pause", 100);
        check("pause_total", int'(bus.count_D0) + int'(bus.count_D1), written);

        // Single VC1 word drains to D0 and returns to IDLE
        glog.delete(); gcyc.delete();
        c0_before = int'(bus.count_D0);
        load(1, 6'b100100);
        drain("single", 50);
        check("single_pops", glog.size(), 1);
        if (glog.size() > 0) check("single_vc", glog[0], 1);
        check("single_count", int'(bus.count_D0), c0_before + 1);
        check("single_data", bus.data_D0, 6'b100100);
        check("single_idle", bus.active, 0);
        repeat (3) step();
        check("single_no_more_pops", glog.size(), 1);

        // Reset one cycle after a pop discards the in-flight word
        for (int i = 0; i < 4; i++) load(0, DW'($urandom()));
        n = 0;
        do begin
            step();
            n++;
        end while (!last_p0 && n < 10);
        check("mr_pop_seen", last_p0, 1);
        reset = 1'b0;
        repeat (2) step();
        check("mr_counts_cleared", {bus.count_D0, bus.count_D1}, 0);
        reset = 1'b1;
        written = q0.size() + q1.size();
        drain("midreset", 50);
        check("mr_total", int'(bus.count_D0) + int'(bus.count_D1), written);

        // Randomized traffic with random backpressure on either destination
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 3) == 0) load(0, DW'($urandom()));
            if ($urandom_range(0, 4) == 0) load(1, DW'($urandom()));
            if ($urandom_range(0, 15) == 0) bus.almost_full_D0 = ~bus.almost_full_D0;
            if ($urandom_range(0, 15) == 0) bus.almost_full_D1 = ~bus.almost_full_D1;
            step();
        end
        bus.almost_full_D0 = 1'b0;
        bus.almost_full_D1 = 1'b0;
        drain("random", 1000);
        check("random_total", (int'(bus.count_D0) + int'(bus.count_D1)) % 256, written % 256);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
